// File: rtl/mul_arb_pkg.sv
// ============================================================================
// Module : mul_arb_pkg
// Brief  : Shared types, defaults and width helpers for the multiplier arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int out_width(input int width);
        return 2 * width;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_rr_picker.sv
// ============================================================================
// Module : mul_rr_picker
// Brief  : Combinational round-robin picker: first valid request at or after rr_ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_rr_picker
    import mul_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any_valid,
    output logic [IDW-1:0]  grant
);

    localparam logic [IDW:0] C_NREQ = (IDW+1)'(NREQ);

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_gsum;

    // Rotate so that bit 0 of w_rot is the requester rr_ptr points at.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_rot
            logic [IDW:0] w_sum;
            logic [IDW:0] w_src;
            assign w_sum    = (IDW+1)'(i) + {1'b0, rr_ptr};
            assign w_src    = (w_sum >= C_NREQ) ? (w_sum - C_NREQ) : w_sum;
            assign w_rot[i] = req_valid[w_src[IDW-1:0]];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
            end
        end
    end

    assign w_gsum    = {1'b0, w_off} + {1'b0, rr_ptr};
    assign any_valid = |req_valid;
    assign grant     = (w_gsum >= C_NREQ) ? IDW'(w_gsum - C_NREQ) : w_gsum[IDW-1:0];

endmodule

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
// ============================================================================
// Module : mul_share_arbiter
// Brief  : Round-robin sharing of one variable-latency multiplier engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int NREQ      = DEF_NREQ,
    parameter  int TIMEOUT   = DEF_TIMEOUT,
    localparam int OUT_WIDTH = out_width(WIDTH),
    localparam int IDW       = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [OUT_WIDTH-1:0]  resp_o,
    output logic                  resp_err,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [OUT_WIDTH-1:0]  mul_o,
    input  logic                  mul_done
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [IDW-1:0]       r_rr_ptr;
    logic [TW-1:0]        r_timer;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic [IDW-1:0]       r_resp_id;
    logic [OUT_WIDTH-1:0] r_resp_o;
    logic                 r_resp_err;

    logic                 w_any_valid;
    logic [IDW-1:0]       w_grant;
    logic [NREQ-1:0]      w_req_ready;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_zero;
    logic                 w_timeout;
    logic [IDW-1:0]       w_rr_next;

    logic [WIDTH-1:0]     w_a_arr [NREQ];
    logic [WIDTH-1:0]     w_b_arr [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_a_arr[i] = req_a[i*WIDTH +: WIDTH];
            assign w_b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    endgenerate

    mul_rr_picker #(
        .NREQ      (NREQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .any_valid (w_any_valid),
        .grant     (w_grant)
    );

    assign w_a       = w_a_arr[w_grant];
    assign w_b       = w_b_arr[w_grant];
    assign w_zero    = (w_a == '0) || (w_b == '0);
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));
    assign w_rr_next = (r_resp_id == IDW'(NREQ - 1)) ? '0 : r_resp_id + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_req_ready[w_grant] = 1'b1;
                    w_state_next         = w_zero ? RESP : ISSUE;
                end
            end
            ISSUE: w_state_next = WAIT;
            WAIT: begin
                // A done on the final timer cycle still wins over the timeout.
                if (mul_done || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_timer    <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_resp_id  <= '0;
            r_resp_o   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_mul_a   <= w_a;
                        r_mul_b   <= w_b;
                        r_resp_id <= w_grant;
                        if (w_zero) begin
                            r_resp_o   <= '0;
                            r_resp_err <= 1'b0;
                        end
                    end
                end
                ISSUE: r_timer <= '0;
                WAIT: begin
                    if (mul_done) begin
                        r_resp_o   <= mul_o;
                        r_resp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_o   <= '0;
                        r_resp_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = (r_state == RESP);
    assign mul_start  = (r_state == ISSUE);
    assign resp_id    = r_resp_id;
    assign resp_o     = r_resp_o;
    assign resp_err   = r_resp_err;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;

endmodule

`default_nettype wire
